// File: rtl/legv8_cache_miss_ctrl.sv
// rtl/legv8_cache_miss_ctrl.sv - LEGv8 cache lookup/miss/fill sequencing FSM with registered outputs.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module legv8_cache_miss_ctrl #(
  parameter int TAG_W = 57,
  parameter int IDX_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [63:0]       req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [IDX_W-1:0]  Index,
  output logic [TAG_W-1:0]  In_Tag,
  output logic              Write,
  input  logic              hit_status,
  output logic              mem_req,
  output logic [63:0]       mem_addr,
  input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MISS_REQ = 3'd2,
    FILL     = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      Write      <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      Index      <= '0;
      In_Tag     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Address fields are captured once here and stay frozen until the next acceptance.
          if (req_valid) begin
            Index     <= req_addr[IDX_W+1:2];
            In_Tag    <= req_addr[63:64-TAG_W];
            mem_addr  <= req_addr & ~64'h3;
            req_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          // An unknown compare result falls into the miss branch.
          if (hit_status) begin
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
            state      <= RESP;
          end else begin
            mem_req <= 1'b1;
            state   <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            Write   <= 1'b1;
            state   <= FILL;
          end
        end
        FILL: begin
          Write      <= 1'b0;
          resp_valid <= 1'b1;
          resp_hit   <= 1'b0;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          Write      <= 1'b0;
          mem_req    <= 1'b0;
        end
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (resp_valid) begin
      if (resp_hit) hit_count <= hit_count + 32'd1;
      else          miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
